uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage, the counterpart of the team's UART transmitter on the same serial link. It synchronises the asynchronous `rxd` line, detects and validates the start bit, samples DATA_BITS data bits LSB-first at mid-bit, and checks the stop bit. Each accepted byte is presented on `data` with a one-cycle `valid` strobe to the downstream consumer (FIFO or command decoder). Malformed frames are flagged on `frame_err`.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_receiver_if.sv | 28 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_receiver.sv | 132 +++++++++++++
 tb/tb_uart_receiver.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM states, default frame
// parameters and serial line levels, common to the RX and TX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_receiver_if.sv
// UART RX output bundle: data, valid strobe, frame_err strobe, busy.
// master = receiver side, slave = downstream consumer.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    input data,
    input valid,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw rxd line, resets to idle (1).
// Ports: clk, rst (async active-low), d (async in), q (synced out).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start detect, mid-bit sampling, stop check.
// Ports: clk, rst (async active-low), rxd (serial in), rx (out bundle).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  uart_receiver_if.master  rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_CNT =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CW-1:0]        clk_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;
  logic                 rxd_s;
  logic                 rxd_prev;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      rxd_prev <= IDLE_LVL;
    end else begin
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      rxd_prev <= rxd_s;
      unique case (state)
        IDLE: begin
          if (rxd_prev == IDLE_LVL &&
              rxd_s == START_LVL) begin
            state   <= START;
            clk_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            // a line back high at mid-start was a glitch
            if (rxd_s == START_LVL) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            // LSB arrives first, so shift in from the top
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            if (rxd_s == STOP_LVL) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q <= 1'b1;
              state  <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        BREAK: begin
          // hold off until the line idles so a stuck-low
          // line cannot look like a stream of start bits
          if (rxd_s == IDLE_LVL) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clk/bit, 8 data bits.
// Monitors log valid/frame_err/busy events; tasks check them.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int overlap  = 0;

  logic       busy_last = 1'b0;
  int         vt[$];
  logic [7:0] vd[$];
  int         ft[$];
  int         br[$];
  int         bf[$];

  uart_receiver_if #(.DATA_BITS(8)) rx ();

  uart_receiver #(
    .CLKS_PER_BIT (16),
    .DATA_BITS    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .rx  (rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx.valid) begin
      vt.push_back(cyc);
      vd.push_back(rx.data);
    end
    if (rx.frame_err) ft.push_back(cyc);
    if (rx.valid && rx.frame_err) overlap <= overlap + 1;
    if (rx.busy && !busy_last) br.push_back(cyc);
    if (!rx.busy && busy_last) bf.push_back(cyc);
    busy_last <= rx.busy;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    vt.delete();
    vd.delete();
    ft.delete();
    br.delete();
    bf.delete();
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop,
                      output int t0);
    t0  = cyc;
    rxd = 1'b0;
    hold(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(16);
    end
    rxd = stop;
    hold(16);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    rxd = 1'b1;
    hold(5);
    checks++;
    if (rx.data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%0h exp=0", rx.data);
    end
    checks++;
    if (rx.valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b exp=0", rx.valid);
    end
    checks++;
    if (rx.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ferr got=%0b exp=0",
               rx.frame_err);
    end
    checks++;
    if (rx.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%0b exp=0", rx.busy);
    end
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      hold(1);
      if (rx.busy !== 1'b0 || rx.valid !== 1'b0 ||
          rx.frame_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_quiet got=%0d bad cycles exp=0", bad);
    end
  endtask

  task automatic test_single();
    int t0;
    clr();
    send(8'hA5, 1'b1, t0);
    hold(20);
    checks++;
    if (vt.size() != 1) begin
      failures++;
      $display("FAIL single_count got=%0d exp=1", vt.size());
    end
    checks++;
    if (vt.size() < 1 || vt[0] != t0 + 155) begin
      failures++;
      $display("FAIL single_time got=%0d exp=%0d",
               vt.size() ? vt[0] - t0 : -1, 155);
    end
    checks++;
    if (vd.size() < 1 || vd[0] !== 8'hA5) begin
      failures++;
      $display("FAIL single_data got=%0h exp=a5",
               vd.size() ? vd[0] : 8'hxx);
    end
    checks++;
    if (ft.size() != 0) begin
      failures++;
      $display("FAIL single_ferr got=%0d exp=0", ft.size());
    end
    checks++;
    if (br.size() < 1 || br[0] != t0 + 3) begin
      failures++;
      $display("FAIL busy_rise got=%0d exp=3",
               br.size() ? br[0] - t0 : -1);
    end
    checks++;
    if (bf.size() < 1 || bf[0] != t0 + 155) begin
      failures++;
      $display("FAIL busy_fall got=%0d exp=155",
               bf.size() ? bf[0] - t0 : -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3];
    int t0, tx;
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h3C;
    clr();
    send(pat[0], 1'b1, t0);
    send(pat[1], 1'b1, tx);
    send(pat[2], 1'b1, tx);
    hold(20);
    checks++;
    if (vt.size() != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", vt.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vt.size() <= i || vt[i] != t0 + 155 + 160 * i) begin
        failures++;
        $display("FAIL b2b_time%0d got=%0d exp=%0d", i,
                 vt.size() > i ? vt[i] - t0 : -1,
                 155 + 160 * i);
      end
      checks++;
      if (vd.size() <= i || vd[i] !== pat[i]) begin
        failures++;
        $display("FAIL b2b_data%0d got=%0h exp=%0h", i,
                 vd.size() > i ? vd[i] : 8'hxx, pat[i]);
      end
    end
  endtask

  task automatic test_glitch();
    clr();
    rxd = 1'b0;
    hold(3);
    rxd = 1'b1;
    hold(9);
    checks++;
    if (br.size() != 1) begin
      failures++;
      $display("FAIL glitch_start got=%0d exp=1", br.size());
    end
    checks++;
    if (rx.busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy got=%0b exp=0", rx.busy);
    end
    hold(40);
    checks++;
    if (vt.size() != 0 || ft.size() != 0) begin
      failures++;
      $display("FAIL glitch_out got=%0d/%0d exp=0/0",
               vt.size(), ft.size());
    end
  endtask

  task automatic test_frame_err();
    int t0;
    clr();
    send(8'h55, 1'b0, t0);
    hold(50);
    checks++;
    if (ft.size() != 1 || ft[0] != t0 + 155) begin
      failures++;
      $display("FAIL ferr_pulse got=%0d at %0d exp=1 at 155",
               ft.size(), ft.size() ? ft[0] - t0 : -1);
    end
    checks++;
    if (vt.size() != 0) begin
      failures++;
      $display("FAIL ferr_valid got=%0d exp=0", vt.size());
    end
    checks++;
    if (rx.data !== 8'h3C) begin
      failures++;
      $display("FAIL ferr_data got=%0h exp=3c", rx.data);
    end
    checks++;
    if (rx.busy !== 1'b1 || br.size() != 1) begin
      failures++;
      $display("FAIL ferr_break got=%0b/%0d exp=1/1",
               rx.busy, br.size());
    end
    rxd = 1'b1;
    hold(20);
    checks++;
    if (rx.busy !== 1'b0) begin
      failures++;
      $display("FAIL break_exit got=%0b exp=0", rx.busy);
    end
    clr();
    send(8'h12, 1'b1, t0);
    hold(20);
    checks++;
    if (vd.size() != 1 || vd[0] !== 8'h12 ||
        vt[0] != t0 + 155) begin
      failures++;
      $display("FAIL after_ferr got=%0d/%0h exp=1/12",
               vd.size(), vd.size() ? vd[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int t0;
    b = 8'hC3;
    clr();
    rxd = 1'b0;
    hold(16);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      hold(16);
    end
    rxd = b[4];
    hold(8);
    rst = 1'b0;
    #1;
    checks++;
    if (rx.busy !== 1'b0 || rx.valid !== 1'b0 ||
        rx.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctl got=%0b%0b%0b exp=000",
               rx.busy, rx.valid, rx.frame_err);
    end
    checks++;
    if (rx.data !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_data got=%0h exp=0", rx.data);
    end
    rxd = 1'b1;
    hold(4);
    rst = 1'b1;
    hold(200);
    checks++;
    if (vt.size() != 0 || ft.size() != 0) begin
      failures++;
      $display("FAIL rst_mid_out got=%0d/%0d exp=0/0",
               vt.size(), ft.size());
    end
    clr();
    send(8'h81, 1'b1, t0);
    hold(20);
    checks++;
    if (vd.size() != 1 || vd[0] !== 8'h81 ||
        vt[0] != t0 + 155) begin
      failures++;
      $display("FAIL rst_mid_next got=%0d/%0h exp=1/81",
               vd.size(), vd.size() ? vd[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL strobe_overlap got=%0d exp=0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
